// File: rtl/maxpool_ctrl_if.sv
// rtl/maxpool_ctrl_if.sv - start/status, input RAM, pooling unit and output RAM signals of maxpool_ctrl
interface maxpool_ctrl_if #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_W    = 10
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [DATA_SIZE-1:0] rd_data;
    logic [DATA_SIZE-1:0] pool_in1;
    logic [DATA_SIZE-1:0] pool_in2;
    logic [DATA_SIZE-1:0] pool_in3;
    logic [DATA_SIZE-1:0] pool_in4;
    logic                 pool_enable;
    logic [DATA_SIZE-1:0] pool_out;
    logic                 pool_done;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_SIZE-1:0] wr_data;

    modport master (
        input  start, rd_data, pool_out, pool_done,
        output busy, done, rd_en, rd_addr,
        output pool_in1, pool_in2, pool_in3, pool_in4, pool_enable,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data, pool_out, pool_done,
        input  busy, done, rd_en, rd_addr,
        input  pool_in1, pool_in2, pool_in3, pool_in4, pool_enable,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/maxpool_ctrl.sv
// rtl/maxpool_ctrl.sv - 2x2 stride-2 max-pool sequencer; define MAXPOOL_RELU_EN to clamp negative results to 0
module maxpool_ctrl #(
    parameter int DATA_SIZE = 8,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int ADDR_W    = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    maxpool_ctrl_if.master bus
);
    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
    localparam logic [ADDR_W-1:0] LAST_WC  = ADDR_W'(OW - 1);
    localparam logic [ADDR_W-1:0] LAST_WR  = ADDR_W'(OH - 1);
    localparam logic [ADDR_W-1:0] W_STEP   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * IMG_W);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_POOL  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]           state;
    logic [2:0]           phase;
    logic [ADDR_W-1:0]    wc;
    logic [ADDR_W-1:0]    wr;
    logic [ADDR_W-1:0]    tl;
    logic [ADDR_W-1:0]    row_base;
    logic [ADDR_W-1:0]    out_addr;
    logic                 rd_en_q;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic                 rd_vld;
    logic [1:0]           rd_sel;
    logic [DATA_SIZE-1:0] pin1, pin2, pin3, pin4;
    logic                 pool_en_q;
    logic                 busy_q;
    logic                 done_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [DATA_SIZE-1:0] wr_data_q;
    logic [DATA_SIZE-1:0] pool_res;
    logic                 write_now;
    logic                 last_win;

`ifdef MAXPOOL_RELU_EN
    assign pool_res = bus.pool_out[DATA_SIZE-1] ? '0 : bus.pool_out;
`else
    assign pool_res = bus.pool_out;
`endif

    // The write strobe follows pool_done in the same cycle, so it cannot be registered.
    assign write_now = ((state == S_WRITE) || (state == S_WAIT)) && bus.pool_done;
    assign last_win  = (wc == LAST_WC) && (wr == LAST_WR);

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.pool_in1    = pin1;
    assign bus.pool_in2    = pin2;
    assign bus.pool_in3    = pin3;
    assign bus.pool_in4    = pin4;
    assign bus.pool_enable = pool_en_q;
    assign bus.wr_en       = write_now;
    assign bus.wr_addr     = write_now ? out_addr : wr_addr_q;
    assign bus.wr_data     = write_now ? pool_res : wr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase     <= '0;
            wc        <= '0;
            wr        <= '0;
            tl        <= '0;
            row_base  <= '0;
            out_addr  <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            pool_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_FETCH;
                        phase     <= '0;
                        wc        <= '0;
                        wr        <= '0;
                        tl        <= '0;
                        row_base  <= '0;
                        out_addr  <= '0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                S_FETCH: begin
                    // Address for the next cycle is staged here so rd_addr is a clean register.
                    phase <= phase + 3'd1;
                    case (phase)
                        3'd0:    rd_addr_q <= tl + ONE;
                        3'd1:    rd_addr_q <= tl + W_STEP;
                        3'd2:    rd_addr_q <= tl + W_STEP + ONE;
                        3'd3:    rd_en_q   <= 1'b0;
                        default: begin
                            state     <= S_POOL;
                            pool_en_q <= 1'b1;
                        end
                    endcase
                end
                S_POOL: begin
                    pool_en_q <= 1'b0;
                    state     <= S_WRITE;
                end
                S_WRITE, S_WAIT: begin
                    if (!bus.pool_done) begin
                        pool_en_q <= 1'b1;
                        state     <= S_WAIT;
                    end else begin
                        pool_en_q <= 1'b0;
                        wr_addr_q <= out_addr;
                        wr_data_q <= pool_res;
                        out_addr  <= out_addr + ONE;
                        if (last_win) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= S_FETCH;
                            phase   <= '0;
                            rd_en_q <= 1'b1;
                            if (wc == LAST_WC) begin
                                wc        <= '0;
                                wr        <= wr + ONE;
                                row_base  <= row_base + ROW_STEP;
                                tl        <= row_base + ROW_STEP;
                                rd_addr_q <= row_base + ROW_STEP;
                            end else begin
                                wc        <= wc + ONE;
                                tl        <= tl + TWO;
                                rd_addr_q <= tl + TWO;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM data lags rd_en by one cycle; rd_sel remembers which window corner it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_sel <= '0;
            pin1   <= '0;
            pin2   <= '0;
            pin3   <= '0;
            pin4   <= '0;
        end else begin
            rd_vld <= rd_en_q;
            rd_sel <= phase[1:0];
            if (rd_vld) begin
                case (rd_sel)
                    2'd0:    pin1 <= bus.rd_data;
                    2'd1:    pin2 <= bus.rd_data;
                    2'd2:    pin3 <= bus.rd_data;
                    default: pin4 <= bus.rd_data;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb/tb_maxpool_ctrl.sv - directed bench for maxpool_ctrl on 4x4, 2x2 and 5x5 maps
module tb_maxpool_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = '0;
    logic [2:0] busy_o, done_o, wr_o;
    logic       clr = 1'b0;
    int         stall_cfg = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         exp4 [4] = '{5, 7, 13, 15};
    int         exp5 [4] = '{60, 50, 10, 0};

    always #5 clk = ~clk;

    function automatic logic [7:0] max4(input logic [7:0] a, b, c, d);
        logic signed [7:0] m;
        m = a;
        if ($signed(b) > m) m = b;
        if ($signed(c) > m) m = c;
        if ($signed(d) > m) m = d;
        return m;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_env
        localparam int IW = (g == 0) ? 4 : (g == 1) ? 2 : 5;
        localparam int IH = IW;

        maxpool_ctrl_if #(.DATA_SIZE(8), .ADDR_W(10)) bus ();

        maxpool_ctrl #(.DATA_SIZE(8), .IMG_W(IW), .IMG_H(IH), .ADDR_W(10)) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus)
        );

        logic [7:0] mem [32];
        logic [7:0] rdq;
        logic [7:0] pout;
        logic       pdone, pend;
        int         stall;
        int         wr_cnt, done_cnt, rd_cnt, bad_rd, en_cyc;
        logic [7:0] wr_d [8];
        logic [9:0] wr_a [8];

        initial begin
            for (int i = 0; i < 32; i++)
                mem[i] = (g == 0) ? 8'(i) : (g == 2) ? 8'(60 - 5 * i) : 8'h00;
            if (g == 1) begin
                mem[0] = 8'hFD;
                mem[1] = 8'hF9;
                mem[2] = 8'hFF;
                mem[3] = 8'hFE;
            end
        end

        assign bus.start     = start_v[g];
        assign bus.rd_data   = rdq;
        assign bus.pool_out  = pout;
        assign bus.pool_done = pdone;
        assign busy_o[g]     = bus.busy;
        assign done_o[g]     = bus.done;
        assign wr_o[g]       = bus.wr_en;

        always @(posedge clk)
            if (bus.rd_en) rdq <= mem[bus.rd_addr[4:0]];

        // Registered pooling unit; a nonzero stall delays pool_done by that many cycles.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pdone <= 1'b0;
                pend  <= 1'b0;
                stall <= 0;
                pout  <= '0;
            end else if (bus.pool_enable || pend) begin
                if (stall > 0) begin
                    stall <= stall - 1;
                    pend  <= 1'b1;
                    pdone <= 1'b0;
                end else begin
                    pout  <= max4(bus.pool_in1, bus.pool_in2, bus.pool_in3, bus.pool_in4);
                    pdone <= 1'b1;
                    pend  <= 1'b0;
                end
            end else begin
                pdone <= 1'b0;
                if (bus.start && !bus.busy) stall <= (g == 0) ? stall_cfg : 0;
            end
        end

        always @(negedge clk) begin
            if (clr) begin
                wr_cnt   <= 0;
                done_cnt <= 0;
                rd_cnt   <= 0;
                bad_rd   <= 0;
                en_cyc   <= 0;
            end else begin
                if (bus.wr_en) begin
                    wr_d[wr_cnt % 8] <= bus.wr_data;
                    wr_a[wr_cnt % 8] <= bus.wr_addr;
                    wr_cnt           <= wr_cnt + 1;
                end
                if (bus.done) done_cnt <= done_cnt + 1;
                if (bus.pool_enable) en_cyc <= en_cyc + 1;
                if (bus.rd_en) begin
                    rd_cnt <= rd_cnt + 1;
                    if ((int'(bus.rd_addr) % IW) >= 2 * (IW / 2) || (int'(bus.rd_addr) / IW) >= 2 * (IH / 2))
                        bad_rd <= bad_rd + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        #1 clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    // Pulses start on instance k, optionally re-pulses it at cycle inj or asserts reset at cycle abort_at.
    task automatic run(input int k, input int inj, input int abort_at,
                       output int cyc, output logic b1, output logic wa);
        @(negedge clk);
        start_v[k] = 1'b1;
        cyc = 0;
        b1  = 1'b0;
        wa  = 1'b0;
        while (cyc < 500) begin
            @(negedge clk);
            cyc++;
            start_v[k] = (cyc == inj);
            if (cyc == 1) b1 = busy_o[k];
            if (cyc == abort_at) begin
                wa = wr_o[k];
                #1 rst_n = 1'b0;
                break;
            end
            if (done_o[k]) break;
        end
        start_v[k] = 1'b0;
    endtask

    task automatic check_inst0(input string t, input int lat, input int exp_lat, input int exp_en);
        repeat (2) @(negedge clk);
        check({t, "_latency"}, lat, exp_lat);
        check({t, "_writes"}, g_env[0].wr_cnt, 4);
        check({t, "_dones"}, g_env[0].done_cnt, 1);
        check({t, "_reads"}, g_env[0].rd_cnt, 16);
        check({t, "_pool_en_cycles"}, g_env[0].en_cyc, exp_en);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_data%0d", t, i), int'(g_env[0].wr_d[i]), exp4[i]);
            check($sformatf("%s_addr%0d", t, i), int'(g_env[0].wr_a[i]), i);
        end
    endtask

    initial begin
        int   cyc;
        logic b1, wa;
        int   relu_exp;

        repeat (3) @(negedge clk);
        check("rst_busy", busy_o[0], 0);
        check("rst_done", done_o[0], 0);
        check("rst_rd_en", g_env[0].bus.rd_en, 0);
        check("rst_rd_addr", g_env[0].bus.rd_addr, 0);
        check("rst_wr_en", g_env[0].bus.wr_en, 0);
        check("rst_pool_en", g_env[0].bus.pool_enable, 0);
        rst_n = 1'b1;

        // 4x4 ramp, nominal timing
        clear_logs();
        run(0, 0, 0, cyc, b1, wa);
        check("t1_busy_after_start", b1, 1);
        check("t1_busy_in_done", busy_o[0], 0);
        @(negedge clk);
        check("t1_done_one_cycle", done_o[0], 0);
        check_inst0("t1", cyc, 29, 4);
        check("t1_hold_wr_addr", g_env[0].bus.wr_addr, 3);
        check("t1_hold_wr_data", g_env[0].bus.wr_data, 15);
        check("t1_hold_rd_addr", g_env[0].bus.rd_addr, 15);

        // 2x2 all-negative map
`ifdef MAXPOOL_RELU_EN
        relu_exp = 0;
`else
        relu_exp = 255;
`endif
        clear_logs();
        run(1, 0, 0, cyc, b1, wa);
        repeat (2) @(negedge clk);
        check("t2_latency", cyc, 8);
        check("t2_writes", g_env[1].wr_cnt, 1);
        check("t2_data", int'(g_env[1].wr_d[0]), relu_exp);
        check("t2_addr", int'(g_env[1].wr_a[0]), 0);

        // 5x5 map: trailing column and row never read
        clear_logs();
        run(2, 0, 0, cyc, b1, wa);
        repeat (2) @(negedge clk);
        check("t3_latency", cyc, 29);
        check("t3_writes", g_env[2].wr_cnt, 4);
        check("t3_reads", g_env[2].rd_cnt, 16);
        check("t3_bad_reads", g_env[2].bad_rd, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_data%0d", i), int'(g_env[2].wr_d[i]), exp5[i]);
            check($sformatf("t3_addr%0d", i), int'(g_env[2].wr_a[i]), i);
        end

        // second start during window 2 is ignored
        clear_logs();
        run(0, 16, 0, cyc, b1, wa);
        check_inst0("t4", cyc, 29, 4);

        // reset during the write of window 1 aborts the pass
        clear_logs();
        run(0, 0, 14, cyc, b1, wa);
        check("t5_in_write", wa, 1);
        #1;
        check("t5_busy", busy_o[0], 0);
        check("t5_rd_en", g_env[0].bus.rd_en, 0);
        check("t5_rd_addr", g_env[0].bus.rd_addr, 0);
        check("t5_wr_en", g_env[0].bus.wr_en, 0);
        check("t5_wr_addr", g_env[0].bus.wr_addr, 0);
        check("t5_pool_en", g_env[0].bus.pool_enable, 0);
        check("t5_pool_in1", g_env[0].bus.pool_in1, 0);
        repeat (3) @(negedge clk);
        check("t5_no_done", g_env[0].done_cnt, 0);
        check("t5_partial_writes", g_env[0].wr_cnt, 2);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        run(0, 0, 0, cyc, b1, wa);
        check_inst0("t5_rerun", cyc, 29, 4);

        // pool_done late by 3 cycles on window 0
        stall_cfg = 3;
        clear_logs();
        run(0, 0, 0, cyc, b1, wa);
        stall_cfg = 0;
        check_inst0("t6", cyc, 32, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
